// File: rtl/pla_pkg.sv
// Shared types for the programmable PLA engine.
// Term records are sized to the widest supported PLA.
package pla_pkg;

  localparam int PLA_IN_W  = 16;
  localparam int PLA_OUT_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } pla_state_e;

  typedef struct packed {
    logic                 en;
    logic [PLA_IN_W-1:0]  care;
    logic [PLA_IN_W-1:0]  pol;
    logic [PLA_OUT_W-1:0] or_row;
  } term_t;

endpackage

// File: rtl/pla_term_chunk.sv
// One chunk of AND-plane terms folded through the OR plane.
// Purely combinational; the caller zero-extends narrow fields.
module pla_term_chunk
  import pla_pkg::*;
#(
  parameter int TERMS_PER_CYCLE = 8
) (
  input  term_t [TERMS_PER_CYCLE-1:0] terms,
  input  logic  [PLA_IN_W-1:0]        x,
  output logic  [PLA_OUT_W-1:0]       part
);

  // A term fires when every cared-for input matches its polarity
  always_comb begin
    part = '0;
    for (int t = 0; t < TERMS_PER_CYCLE; t++) begin
      if (terms[t].en &&
          (((x ^ terms[t].pol) & terms[t].care) == '0)) begin
        part = part | terms[t].or_row;
      end
    end
  end

endmodule

// File: rtl/pla_prog_engine.sv
// Programmable PLA: term table plus chunked IDLE/EVAL/DONE evaluator.
// Optional PLA_PROG_READBACK_EN adds a registered term readback port.
module pla_prog_engine
  import pla_pkg::*;
#(
  parameter int NUM_IN          = 8,
  parameter int NUM_OUT         = 38,
  parameter int NUM_TERMS       = 64,
  parameter int TERMS_PER_CYCLE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prog_valid,
  output logic                         prog_ready,
  input  logic [$clog2(NUM_TERMS)-1:0] prog_idx,
  input  logic                         prog_en,
  input  logic [NUM_IN-1:0]            prog_care,
  input  logic [NUM_IN-1:0]            prog_pol,
  input  logic [NUM_OUT-1:0]           prog_or,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_IN-1:0]            x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_OUT-1:0]           z
`ifdef PLA_PROG_READBACK_EN
  ,
  input  logic [$clog2(NUM_TERMS)-1:0] rd_idx,
  output logic                         rd_en,
  output logic [NUM_IN-1:0]            rd_care,
  output logic [NUM_IN-1:0]            rd_pol,
  output logic [NUM_OUT-1:0]           rd_or
`endif
);

  localparam int IW  = $clog2(NUM_TERMS);
  localparam int TPC = TERMS_PER_CYCLE;
  localparam int K   = NUM_TERMS / TPC;
  localparam int CW  = (K > 1) ? $clog2(K) : 1;

  pla_state_e             state;
  logic [NUM_TERMS-1:0]   en_q;
  logic [NUM_IN-1:0]      care_q [NUM_TERMS];
  logic [NUM_IN-1:0]      pol_q  [NUM_TERMS];
  logic [NUM_OUT-1:0]     or_q   [NUM_TERMS];
  logic [NUM_IN-1:0]      x_q;
  logic [PLA_OUT_W-1:0]   acc;
  logic [PLA_OUT_W-1:0]   part;
  logic [NUM_OUT-1:0]     z_q;
  logic [CW-1:0]          cnt;
  logic                   prog_fire;
  term_t [TPC-1:0]        chunk;

  assign prog_ready = (state != S_EVAL);
  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign z          = z_q;
  assign prog_fire  = prog_valid && prog_ready;

  // Enable bits are the only table state that reset must clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
    end else if (prog_fire) begin
      en_q[prog_idx] <= prog_en;
    end
  end

  // Care/polarity/OR rows are don't-care until enabled
  always_ff @(posedge clk) begin
    if (prog_fire) begin
      care_q[prog_idx] <= prog_care;
      pol_q[prog_idx]  <= prog_pol;
      or_q[prog_idx]   <= prog_or;
    end
  end

  // Gather the chunk selected by the counter into term records
  always_comb begin
    logic [IW-1:0] i_t;
    i_t   = '0;
    chunk = '0;
    for (int t = 0; t < TPC; t++) begin
      i_t                = IW'(int'(cnt) * TPC + t);
      chunk[t].en        = en_q[i_t];
      chunk[t].care      = PLA_IN_W'(care_q[i_t]);
      chunk[t].pol       = PLA_IN_W'(pol_q[i_t]);
      chunk[t].or_row    = PLA_OUT_W'(or_q[i_t]);
    end
  end

  pla_term_chunk #(
    .TERMS_PER_CYCLE(TPC)
  ) u_chunk (
    .terms(chunk),
    .x    (PLA_IN_W'(x_q)),
    .part (part)
  );

  // Evaluator FSM: latch x, sweep K chunks, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      z_q   <= '0;
      x_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_EVAL;
            x_q   <= x;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        S_EVAL: begin
          if (cnt == CW'(K - 1)) begin
            state <= S_DONE;
            z_q   <= NUM_OUT'(acc | part);
            cnt   <= '0;
          end else begin
            acc <= acc | part;
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PLA_PROG_READBACK_EN
  // Readback of one stored term, one cycle after rd_idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_care <= '0;
      rd_pol  <= '0;
      rd_or   <= '0;
    end else begin
      rd_en   <= en_q[rd_idx];
      rd_care <= care_q[rd_idx];
      rd_pol  <= pol_q[rd_idx];
      rd_or   <= or_q[rd_idx];
    end
  end
`endif

endmodule

// File: tb/tb_pla_prog_engine.sv
// Bench for pla_prog_engine: vector table plus corner sequences.
// Expected z values are queued at issue and popped at completion.
module tb_pla_prog_engine;

  localparam int NI = 8;
  localparam int NO = 38;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_valid = 1'b0;
  logic          prog_ready;
  logic [IW-1:0] prog_idx = '0;
  logic          prog_en = 1'b0;
  logic [NI-1:0] prog_care = '0;
  logic [NI-1:0] prog_pol = '0;
  logic [NO-1:0] prog_or = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NI-1:0] x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NO-1:0] z;

  pla_prog_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_valid(prog_valid),
    .prog_ready(prog_ready),
    .prog_idx  (prog_idx),
    .prog_en   (prog_en),
    .prog_care (prog_care),
    .prog_pol  (prog_pol),
    .prog_or   (prog_or),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0] x;
    logic [NO-1:0] z;
  } vec_t;

  vec_t          tbl [6];
  logic [NO-1:0] sb [$];
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prog(input logic [IW-1:0] idx, input logic en,
                      input logic [NI-1:0] care, input logic [NI-1:0] pol,
                      input logic [NO-1:0] orr);
    int n;
    @(negedge clk);
    prog_idx = idx; prog_en = en; prog_care = care;
    prog_pol = pol; prog_or = orr; prog_valid = 1'b1;
    n = 0;
    while (!prog_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("prog_timeout", 1, 0);
    @(negedge clk);
    prog_valid = 1'b0;
  endtask

  task automatic start_eval(input logic [NI-1:0] xv);
    int n;
    @(negedge clk);
    x = xv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("in_timeout", 1, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_eval(input string name);
    int n;
    logic [NO-1:0] e;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({name, "_latency"}, n, 8);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({name, "_z"}, z, e);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
  endtask

  task automatic eval(input logic [NI-1:0] xv, input logic [NO-1:0] e,
                      input string name);
    sb.push_back(e);
    start_eval(xv);
    finish_eval(name);
    release_out();
  endtask

  initial begin
    int  bad;
    int  n;
    logic [NO-1:0] zh;

    tbl[0] = '{8'h5A, 38'h20_0000_0008};
    tbl[1] = '{8'h5B, 38'h20_0000_0000};
    tbl[2] = '{8'h05, 38'h20_0000_0001};
    tbl[3] = '{8'hF5, 38'h20_0000_0001};
    tbl[4] = '{8'h00, 38'h20_0000_0000};
    tbl[5] = '{8'hFF, 38'h20_0000_0000};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_prog_ready", prog_ready, 1);

    eval(8'h5A, '0, "empty");

    prog(6'd0, 1'b1, 8'hFF, 8'h5A, 38'h8);
    eval(8'h5A, 38'h8, "t0_hit");
    eval(8'h5B, 38'h0, "t0_miss");

    prog(6'd17, 1'b1, 8'h0F, 8'h05, 38'h1);
    prog(6'd40, 1'b0, 8'h00, 8'h00, 38'h400);
    prog(6'd63, 1'b1, 8'h00, 8'h00, 38'h20_0000_0000);

    for (int i = 0; i < 6; i++) begin
      eval(tbl[i].x, tbl[i].z, $sformatf("vec%0d", i));
    end

    // hold in DONE, with a write landing while held
    sb.push_back(38'h20_0000_0000);
    start_eval(8'h00);
    finish_eval("hold");
    zh  = z;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || z !== zh) bad++;
    end
    check("hold_stable", bad, 0);
    prog(6'd1, 1'b1, 8'h00, 8'h00, 38'h20);
    check("done_write_z", z, 38'h20_0000_0000);
    check("done_write_valid", out_valid, 1);
    release_out();
    eval(8'h00, 38'h20_0000_0020, "after_done_write");

    // write requested during EVAL stalls until DONE
    sb.push_back(38'h20_0000_0020);
    start_eval(8'h00);
    @(negedge clk);
    prog_idx = 6'd60; prog_en = 1'b1; prog_care = '0;
    prog_pol = '0; prog_or = 38'h40; prog_valid = 1'b1;
    check("eval_prog_ready", prog_ready, 0);
    n = 0;
    while (!prog_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("eval_write_in_done", out_valid, 1);
    @(negedge clk);
    prog_valid = 1'b0;
    zh = sb.pop_front();
    check("eval_write_z", z, zh);
    release_out();
    eval(8'h00, 38'h20_0000_0060, "after_eval_write");

    // same-edge write and evaluation request
    @(negedge clk);
    prog_idx = 6'd8; prog_en = 1'b1; prog_care = '0;
    prog_pol = '0; prog_or = 38'h10_0000; prog_valid = 1'b1;
    x = 8'h00; in_valid = 1'b1;
    @(posedge clk);
    #1 prog_valid = 1'b0; in_valid = 1'b0;
    sb.push_back(38'h20_0010_0060);
    finish_eval("same_edge");
    release_out();

    // reset in the middle of EVAL aborts the run
    start_eval(8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("abort_in_ready", in_ready, 1);
    check("abort_z", z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1 if (out_valid) bad++;
    end
    check("abort_no_valid", bad, 0);
    eval(8'h00, '0, "post_abort");
    eval(8'h5A, '0, "post_abort_5a");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
